seq_muldiv_unit: RTL and testbench
==================================

// Module: seq_muldiv_unit
// PURPOSE
//  Iterative multi-cycle multiply/divide unit: the sequential companion to the combinational ALU.
//  Implements ALUControl ops DIV/MUL/REM (0x0B/0x0C/0x0D) plus MULH/MULHU/DIVU/REMU.
//  Sits beside the ALU in execute; issue side and writeback side use valid/ready handshakes.
//  Radix-2 shift-add multiply, restoring divide; one operation in flight.
// PARAMETERS
//  WIDTH   32  operand/result width (even, >=4)
//  OP_W    6   opcode width, matches ALUControl
//  CNT_W   $clog2(WIDTH)+1  iteration counter width (derived, localparam)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      synchronous reset, active-low
//  in_valid   in   1      op/a/b valid
//  in_ready   out  1      unit can accept (high only in IDLE)
//  op         in   OP_W   operation code
//  a, b       in   WIDTH  operand A (dividend/multiplicand), operand B
//  out_valid  out  1      result valid, held until out_ready
//  out_ready  in   1      consumer accepts result
//  result     out  WIDTH  result
//  zero       out  1      result == 0
//  negative   out  1      result[WIDTH-1]
//  overflow   out  1      signed DIV/REM of MIN by -1
//  div_zero   out  1      DIV/DIVU/REM/REMU with b == 0
//  illegal    out  1      op not in table; result 0
// BEHAVIOUR
//  Reset: one clock, synchronous, active-low; state=IDLE; out_valid, result, all flags = 0; in_ready=1.
//  Ops: MUL 0x0C low half; MULH 0x0E signed high; MULHU 0x0F unsigned high; DIV 0x0B signed q;
//    DIVU 0x10 unsigned q; REM 0x0D signed r (sign of a); REMU 0x11 unsigned r.
//  Accept on in_valid & in_ready; op/a/b captured into internal regs, ports then ignored.
//  FSM: IDLE -accept-> PREP (abs values, record result sign) -> RUN (WIDTH iterations, cnt WIDTH-1..0)
//    -> FIX (negate if needed, select half, compute flags) -> DONE.
//    DONE -out_ready-> IDLE. out_valid=1 only in DONE; result/flags stable while out_valid & !out_ready.
//  Latency: accept edge to out_valid = WIDTH+2 cycles (34 at WIDTH=32). Fixed for every op incl. illegal.
//  Throughput: next accept no earlier than the cycle after the result handshake (in_ready=0 in DONE).
//  Multiply: 2*WIDTH product reg; signed MULH uses abs operands, negates the 2W product when signs differ.
//  Divide by zero: q = all ones, r = a (unmodified), div_zero=1, overflow=0.
//  Signed overflow (a=MIN, b=-1): q = MIN, r = 0, overflow=1.
//  Illegal op: result 0, illegal=1, zero=1, same latency.
//  Flags zero/negative are computed from the final result for every op.
//  rst_n low in any state aborts the op next edge, no output produced; out_valid drops.
// CONFIGURATION
//  SEQ_MULDIV_BYPASS_EN defined: div-by-zero, b==0 multiply, and divide-by-1 skip RUN: PREP->FIX,
//    out_valid 2 cycles after accept; results/flags bit-identical to non-bypass path.
//  Undefined: every op takes fixed WIDTH+2 latency; no bypass logic synthesised.
// STRUCTURE
//  Package muldiv_pkg: opcode localparams (OP_MUL..OP_REMU), FSM state enum (IDLE,PREP,RUN,FIX,DONE),
//    helper function for two's-complement abs.
//  One sub-module muldiv_step: combinational single iteration (add-shift for multiply,
//    trial-subtract/restore for divide), instantiated once inside the RUN datapath.
// TESTING (WIDTH=32)
//  MUL a=7,b=-3 -> result 0xFFFFFFEB, negative=1, out_valid exactly 34 cycles after accept.
//  MULH a=0x80000000,b=0x80000000 -> 0x40000000; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE.
//  DIV a=-7,b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU a=100,b=7 -> 14; REMU -> 2.
//  DIV a=5,b=0 -> 0xFFFFFFFF, div_zero=1; REM a=5,b=0 -> 5; DIV 0x80000000/-1 -> 0x80000000, overflow=1.
//  Hold out_ready=0 for 10 cycles in DONE -> result/flags stable, in_ready=0; then accept back-to-back op.
//  Drop rst_n mid-RUN -> next edge out_valid=0, in_ready=1, no stale result; op 0x3F -> result 0, illegal=1.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants for the sequential multiply/divide unit: opcodes, FSM state codes
// and a two's-complement magnitude helper.
package muldiv_pkg;

    localparam logic [5:0] OP_DIV   = 6'h0B;
    localparam logic [5:0] OP_MUL   = 6'h0C;
    localparam logic [5:0] OP_REM   = 6'h0D;
    localparam logic [5:0] OP_MULH  = 6'h0E;
    localparam logic [5:0] OP_MULHU = 6'h0F;
    localparam logic [5:0] OP_DIVU  = 6'h10;
    localparam logic [5:0] OP_REMU  = 6'h11;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PREP = 3'd1;
    localparam logic [2:0] ST_RUN  = 3'd2;
    localparam logic [2:0] ST_FIX  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // Callers sign-extend into this width and truncate the result back, so WIDTH < 128.
    localparam int MD_ABS_W = 128;

    function automatic logic [MD_ABS_W-1:0] twos_abs(input logic [MD_ABS_W-1:0] v);
        return v[MD_ABS_W-1] ? (~v + 128'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, trial-subtract/restore for divide.
// {i_hi,i_lo} is the product/partial-remainder pair, i_opnd the multiplicand or divisor.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_opnd,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_trial;

    // Single iteration of either algorithm, selected by the operation class.
    always_comb begin
        w_sum   = {1'b0, i_hi} + {1'b0, (i_lo[0] ? i_opnd : {WIDTH{1'b0}})};
        w_trial = {i_hi, i_lo[WIDTH-1]} - {1'b0, i_opnd};
        o_hi    = {WIDTH{1'b0}};
        o_lo    = {WIDTH{1'b0}};
        if (i_is_div) begin
            // A borrow means the shifted remainder was below 2^WIDTH, so its top bit is 0.
            if (!w_trial[WIDTH]) begin
                o_hi = w_trial[WIDTH-1:0];
                o_lo = {i_lo[WIDTH-2:0], 1'b1};
            end else begin
                o_hi = {i_hi[WIDTH-2:0], i_lo[WIDTH-1]};
                o_lo = {i_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            o_hi = w_sum[WIDTH:1];
            o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/seq_muldiv_unit.sv
// Iterative multiply/divide unit (MUL/MULH/MULHU/DIV/DIVU/REM/REMU), one op in flight.
// Optional SEQ_MULDIV_BYPASS_EN: trivial divisors/multipliers skip the iteration phase.
module seq_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OP_W  = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             overflow,
    output logic             div_zero,
    output logic             illegal
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [OP_W-1:0]  r_op;
    logic [WIDTH-1:0] r_a, r_b, r_hi, r_lo, r_opnd, r_result;
    logic             r_neg, r_zero, r_negative, r_overflow, r_div_zero, r_illegal;
    logic             r_out_valid, r_in_ready;

    logic             w_is_div, w_is_signed, w_legal, w_neg, w_ovf, w_dz;
    logic [WIDTH-1:0] w_sa, w_sb, w_step_hi, w_step_lo, w_mulh, w_fix_result;

    // Operation class decode from the captured opcode.
    always_comb begin
        w_is_div    = 1'b0;
        w_is_signed = 1'b0;
        w_legal     = 1'b1;
        case (r_op)
            OP_MUL:   w_is_div = 1'b0;
            OP_MULH:  w_is_signed = 1'b1;
            OP_MULHU: w_is_signed = 1'b0;
            OP_DIV:   begin w_is_div = 1'b1; w_is_signed = 1'b1; end
            OP_DIVU:  w_is_div = 1'b1;
            OP_REM:   begin w_is_div = 1'b1; w_is_signed = 1'b1; end
            OP_REMU:  w_is_div = 1'b1;
            default:  w_legal = 1'b0;
        endcase
    end

    assign w_sa  = w_is_signed ? WIDTH'(twos_abs(MD_ABS_W'($signed(r_a)))) : r_a;
    assign w_sb  = w_is_signed ? WIDTH'(twos_abs(MD_ABS_W'($signed(r_b)))) : r_b;
    // Remainder takes the dividend's sign; quotient and high product take the XOR.
    assign w_neg = w_is_signed & ((r_op == OP_REM) ? r_a[WIDTH-1] : (r_a[WIDTH-1] ^ r_b[WIDTH-1]));
    assign w_dz  = w_is_div & (r_b == {WIDTH{1'b0}});
    assign w_ovf = ((r_op == OP_DIV) | (r_op == OP_REM)) & (r_a == MIN_VAL) & (r_b == {WIDTH{1'b1}});
    // High half of -{hi,lo}: invert hi, carry in only when the low half is zero.
    assign w_mulh = r_neg ? (~r_hi + {{(WIDTH-1){1'b0}}, (r_lo == {WIDTH{1'b0}})}) : r_hi;

`ifdef SEQ_MULDIV_BYPASS_EN
    logic w_skip;
    // Divide by 0/1 and multiply by 0 are already final after PREP's preload.
    assign w_skip = w_legal & (w_is_div ? ((r_b == {WIDTH{1'b0}}) | (r_b == {{(WIDTH-1){1'b0}}, 1'b1}))
                                        : (r_b == {WIDTH{1'b0}}));
`endif

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_is_div (w_is_div),
        .i_hi     (r_hi),
        .i_lo     (r_lo),
        .i_opnd   (r_opnd),
        .o_hi     (w_step_hi),
        .o_lo     (w_step_lo)
    );

    // Final result selection: sign fix-up, half selection and divide special cases.
    always_comb begin
        w_fix_result = {WIDTH{1'b0}};
        case (r_op)
            OP_MUL:   w_fix_result = r_lo;
            OP_MULH:  w_fix_result = w_mulh;
            OP_MULHU: w_fix_result = r_hi;
            OP_DIV:   w_fix_result = w_dz ? {WIDTH{1'b1}} : (r_neg ? -r_lo : r_lo);
            OP_DIVU:  w_fix_result = w_dz ? {WIDTH{1'b1}} : r_lo;
            OP_REM:   w_fix_result = w_dz ? r_a : (r_neg ? -r_hi : r_hi);
            OP_REMU:  w_fix_result = w_dz ? r_a : r_hi;
            default:  w_fix_result = {WIDTH{1'b0}};
        endcase
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= {CNT_W{1'b0}};
            r_op        <= {OP_W{1'b0}};
            r_a         <= {WIDTH{1'b0}};
            r_b         <= {WIDTH{1'b0}};
            r_hi        <= {WIDTH{1'b0}};
            r_lo        <= {WIDTH{1'b0}};
            r_opnd      <= {WIDTH{1'b0}};
            r_neg       <= 1'b0;
            r_result    <= {WIDTH{1'b0}};
            r_zero      <= 1'b0;
            r_negative  <= 1'b0;
            r_overflow  <= 1'b0;
            r_div_zero  <= 1'b0;
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_op       <= op;
                        r_a        <= a;
                        r_b        <= b;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    // Multiplier (b) is consumed from lo; dividend (a) is shifted out of lo.
                    r_hi   <= {WIDTH{1'b0}};
                    r_lo   <= w_is_div ? w_sa : w_sb;
                    r_opnd <= w_is_div ? w_sb : w_sa;
                    r_neg  <= w_neg;
                    r_cnt  <= CNT_W'(WIDTH - 1);
`ifdef SEQ_MULDIV_BYPASS_EN
                    r_state <= w_skip ? ST_FIX : ST_RUN;
`else
                    r_state <= ST_RUN;
`endif
                end
                ST_RUN: begin
                    r_hi <= w_step_hi;
                    r_lo <= w_step_lo;
                    if (r_cnt == {CNT_W{1'b0}}) begin
                        r_state <= ST_FIX;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    r_result    <= w_fix_result;
                    r_zero      <= (w_fix_result == {WIDTH{1'b0}});
                    r_negative  <= w_fix_result[WIDTH-1];
                    r_overflow  <= w_ovf;
                    r_div_zero  <= w_dz;
                    r_illegal   <= ~w_legal;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign negative  = r_negative;
    assign overflow  = r_overflow;
    assign div_zero  = r_div_zero;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_seq_muldiv_unit.sv
// Bench for seq_muldiv_unit: arithmetic reference model plus directed vectors with
// hand-computed results; every output cycle is compared against the model.
module tb_seq_muldiv_unit;

    logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [5:0]  op;
    logic [31:0] a, b, result;
    logic        zero, negative, overflow, div_zero, illegal;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int next_id = 0;
    int last_lat_id = -1;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flags;   // {illegal, div_zero, overflow, negative, zero}
        int          acc;
        int          id;
        int          lat;
    } exp_t;

    exp_t expq[$];

    seq_muldiv_unit #(.WIDTH(32), .OP_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .negative(negative), .overflow(overflow),
        .div_zero(div_zero), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y,
                                   input int acc, input int id);
        exp_t e;
        longint sx, sy;
        logic [63:0] p, ux, uy;
        logic ovf, dz, ill, skip;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        ovf = 1'b0; dz = 1'b0; ill = 1'b0; skip = 1'b0;
        e.res = 32'd0;
        case (o)
            6'h0C: begin p = sx * sy; e.res = p[31:0]; skip = (y == 32'd0); end
            6'h0E: begin p = sx * sy; e.res = p[63:32]; skip = (y == 32'd0); end
            6'h0F: begin p = ux * uy; e.res = p[63:32]; skip = (y == 32'd0); end
            6'h0B: begin
                skip = (y == 32'd0) || (y == 32'd1);
                if (y == 32'd0) begin dz = 1'b1; e.res = 32'hFFFFFFFF; end
                else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin ovf = 1'b1; e.res = 32'h80000000; end
                else begin p = sx / sy; e.res = p[31:0]; end
            end
            6'h10: begin
                skip = (y == 32'd0) || (y == 32'd1);
                if (y == 32'd0) begin dz = 1'b1; e.res = 32'hFFFFFFFF; end
                else begin p = ux / uy; e.res = p[31:0]; end
            end
            6'h0D: begin
                skip = (y == 32'd0) || (y == 32'd1);
                if (y == 32'd0) begin dz = 1'b1; e.res = x; end
                else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin ovf = 1'b1; e.res = 32'd0; end
                else begin p = sx % sy; e.res = p[31:0]; end
            end
            6'h11: begin
                skip = (y == 32'd0) || (y == 32'd1);
                if (y == 32'd0) begin dz = 1'b1; e.res = x; end
                else begin p = ux % uy; e.res = p[31:0]; end
            end
            default: ill = 1'b1;
        endcase
        e.flags = {ill, dz, ovf, e.res[31], (e.res == 32'd0)};
        e.acc = acc;
        e.id  = id;
`ifdef SEQ_MULDIV_BYPASS_EN
        e.lat = skip ? 2 : 34;
`else
        e.lat = skip ? 34 : 34;
`endif
        return e;
    endfunction

    // Records accepted operations and retires them on the result handshake.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            expq.delete();
        end else begin
            if (out_valid && out_ready && expq.size() > 0) void'(expq.pop_front());
            if (in_valid && in_ready) begin
                expq.push_back(model(op, a, b, cyc, next_id));
                next_id <= next_id + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic compare_cycle();
        if (rst_n && out_valid) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_valid actual=1 expected=0 result=%0h (cycle %0d)", result, cyc);
            end else begin
                exp_t e;
                e = expq[0];
                chk("model_result", result, e.res);
                chk("model_flags", {illegal, div_zero, overflow, negative, zero}, e.flags);
                chk("in_ready_in_done", in_ready, 1'b0);
                if (e.id != last_lat_id) begin
                    last_lat_id = e.id;
                    chk("latency", cyc - e.acc - 1, e.lat);
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_cycle();
    endtask

    task automatic run_op(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] lr, input logic [4:0] lf, input int hold);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        chk("accept_wait", in_ready, 1'b1);
        op = o; a = x; b = y; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 60) begin tick(); n++; end
        chk("done_wait", out_valid, 1'b1);
        chk("lit_result", result, lr);
        chk("lit_flags", {illegal, div_zero, overflow, negative, zero}, lf);
        repeat (hold) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 6'd0; a = 32'd0; b = 32'd0;
        tick(); tick();
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_result", result, 32'd0);
        chk("reset_flags", {illegal, div_zero, overflow, negative, zero}, 5'd0);
        rst_n = 1'b1;
        tick();

        run_op(6'h0C, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 5'b00010, 0);
        run_op(6'h0E, 32'h80000000, 32'h80000000, 32'h40000000, 5'b00000, 0);
        run_op(6'h0F, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 5'b00010, 0);
        run_op(6'h0E, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 5'b00010, 0);
        run_op(6'h0B, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 5'b00010, 0);
        run_op(6'h0D, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 5'b00010, 0);
        run_op(6'h10, 32'd100,      32'd7,        32'd14,       5'b00000, 0);
        run_op(6'h11, 32'd100,      32'd7,        32'd2,        5'b00000, 0);
        run_op(6'h0B, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 5'b00010, 0);
        run_op(6'h0D, 32'd7,        32'hFFFFFFFE, 32'd1,        5'b00000, 0);
        run_op(6'h0B, 32'd5,        32'd0,        32'hFFFFFFFF, 5'b01010, 0);
        run_op(6'h0D, 32'd5,        32'd0,        32'd5,        5'b01000, 0);
        run_op(6'h10, 32'd5,        32'd0,        32'hFFFFFFFF, 5'b01010, 0);
        run_op(6'h11, 32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 5'b01010, 0);
        run_op(6'h0B, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 5'b00110, 0);
        run_op(6'h0D, 32'h80000000, 32'hFFFFFFFF, 32'd0,        5'b00101, 0);
        run_op(6'h0C, 32'h12345678, 32'd0,        32'd0,        5'b00001, 0);
        run_op(6'h11, 32'd7,        32'd1,        32'd0,        5'b00001, 0);
        run_op(6'h3F, 32'd9,        32'd3,        32'd0,        5'b10001, 0);
        // Held result, then a back-to-back issue right after the handshake.
        run_op(6'h0C, 32'd6,        32'd7,        32'd42,       5'b00000, 10);
        run_op(6'h10, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 5'b00010, 0);

        // Abort in the middle of the iteration phase.
        op = 6'h0C; a = 32'd3; b = 32'd5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_in_ready", in_ready, 1'b1);
        chk("abort_result", result, 32'd0);
        rst_n = 1'b1;
        repeat (40) tick();
        chk("abort_no_output", out_valid, 1'b0);
        run_op(6'h0C, 32'd3,        32'd5,        32'd15,       5'b00000, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
